// File: rtl/score_keeper_pkg.sv
// -----------------------------------------------------------------------------
// score_pkg
// Shared types and constants for the score keeper block.
//   state_e       : round state encoding (2'd3 is unused and recovers to IDLE)
//   SCORE_W       : width of score / high_score (feeds a 0..99 ASCII converter)
//   MAX_SCORE_DEF : default saturation ceiling
//   sat_add()     : saturating score + points, computed without wrap
// -----------------------------------------------------------------------------
package score_pkg;

  localparam int SCORE_W       = 7;
  localparam int COMBO_W       = 2;
  localparam int MAX_SCORE_DEF = 99;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAYING = 2'd1,
    ST_OVER    = 2'd2
  } state_e;

  // One extra bit of headroom so 99 + 3 cannot wrap before the clamp.
  function automatic logic [SCORE_W-1:0] sat_add(
    input logic [SCORE_W-1:0] score,
    input logic [COMBO_W-1:0] points,
    input logic [SCORE_W-1:0] ceiling
  );
    logic [SCORE_W:0] sum;
    sum = {1'b0, score} + {{(SCORE_W+1-COMBO_W){1'b0}}, points};
    return (sum > {1'b0, ceiling}) ? ceiling : sum[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/score_keeper_if.sv
// -----------------------------------------------------------------------------
// score_keeper_if
// Groups the game-event inputs and score outputs of score_keeper.
//   start, game_over, hit : level inputs from the game-logic stage
//   score, high_score     : 0..MAX_SCORE, to the score-to-ASCII path
//   combo                 : points the next hit will award
//   new_record, playing   : round status flags
// Modports: master = game logic / display side, slave = score_keeper.
// -----------------------------------------------------------------------------
interface score_keeper_if;
  import score_pkg::*;

  logic               start;
  logic               game_over;
  logic               hit;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] high_score;
  logic [COMBO_W-1:0] combo;
  logic               new_record;
  logic               playing;

  modport master (
    output start, game_over, hit,
    input  score, high_score, combo, new_record, playing
  );

  modport slave (
    input  start, game_over, hit,
    output score, high_score, combo, new_record, playing
  );
endinterface

// File: rtl/score_keeper_combo_timer.sv
// -----------------------------------------------------------------------------
// combo_timer
// Combo multiplier with its expiry timer.
//   clk, rst  : clock, async active-high reset
//   clear     : round start/end; combo back to 1, timer stopped
//   hit_evt   : one-cycle hit event (already qualified by the FSM)
//   combo     : points the next hit will award, 1..MAX_COMBO
// A hit reloads the timer with COMBO_WINDOW; the combo drops to 1 on the edge
// where the timer runs out, i.e. COMBO_WINDOW edges after the last hit.
// Outside a round the timer is always 0, so the countdown needs no enable.
// -----------------------------------------------------------------------------
module combo_timer
  import score_pkg::*;
#(
  parameter int MAX_COMBO    = 3,
  parameter int COMBO_WINDOW = 65_000_000,
  parameter int TMR_W        = 26
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               hit_evt,
  output logic [COMBO_W-1:0] combo
);

  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [COMBO_W-1:0] combo_q, combo_d;

  // NOTE: every variable assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    timer_d = timer_q;
    combo_d = combo_q;
    if (clear) begin
      timer_d = '0;
      combo_d = COMBO_W'(1);
    end else if (hit_evt) begin
      timer_d = TMR_W'(COMBO_WINDOW);
      combo_d = (combo_q >= COMBO_W'(MAX_COMBO)) ? COMBO_W'(MAX_COMBO)
                                                 : combo_q + COMBO_W'(1);
    end else if (timer_q == TMR_W'(1)) begin
      timer_d = '0;
      combo_d = COMBO_W'(1);
    end else if (timer_q != '0) begin
      timer_d = timer_q - TMR_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= '0;
      combo_q <= COMBO_W'(1);
    end else begin
      timer_q <= timer_d;
      combo_q <= combo_d;
    end
  end

  assign combo = combo_q;

endmodule

// File: rtl/score_keeper.sv
// -----------------------------------------------------------------------------
// score_keeper
// Round state machine, hit edge detect, score and session high score.
//   clk, rst : 65 MHz pixel clock, async active-high reset
//   bus      : score_keeper_if.slave (start/game_over/hit in,
//              score/high_score/combo/new_record/playing out)
// All outputs are registered. score and high_score never leave 0..MAX_SCORE.
// Priority inside a round: game_over beats a simultaneous hit and start.
// -----------------------------------------------------------------------------
module score_keeper
  import score_pkg::*;
#(
  parameter int MAX_SCORE    = MAX_SCORE_DEF,
  parameter int MAX_COMBO    = 3,
  parameter int COMBO_WINDOW = 65_000_000,
  parameter int TMR_W        = 26
) (
  input  logic          clk,
  input  logic          rst,
  score_keeper_if.slave bus
);

  state_e             state_q, state_d;
  logic               hit_d_q;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] high_q, high_d;
  logic               new_record_q, new_record_d;
  logic               playing_q;
  logic [COMBO_W-1:0] combo_w;

  logic round_start;
  logic round_end;
  logic hit_evt;

  // Next state and the per-edge control strobes.
  always_comb begin
    state_d     = state_q;
    round_start = 1'b0;
    round_end   = 1'b0;
    hit_evt     = 1'b0;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (bus.start) begin
          state_d     = ST_PLAYING;
          round_start = 1'b1;
        end
      end
      ST_PLAYING: begin
        if (bus.game_over) begin
          state_d   = ST_OVER;
          round_end = 1'b1;
        end else begin
          // Rising edge only: a held level scores once.
          hit_evt = bus.hit & ~hit_d_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Score / record datapath.
  always_comb begin
    score_d      = score_q;
    high_d       = high_q;
    new_record_d = new_record_q;
    if (round_start) begin
      score_d      = '0;
      new_record_d = 1'b0;
    end else if (round_end) begin
      if (score_q > high_q) begin
        high_d       = score_q;
        new_record_d = 1'b1;
      end
    end else if (hit_evt) begin
      score_d = sat_add(score_q, combo_w, SCORE_W'(MAX_SCORE));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      hit_d_q      <= 1'b0;
      score_q      <= '0;
      high_q       <= '0;
      new_record_q <= 1'b0;
      playing_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hit_d_q      <= bus.hit;
      score_q      <= score_d;
      high_q       <= high_d;
      new_record_q <= new_record_d;
      playing_q    <= (state_d == ST_PLAYING);
    end
  end

  combo_timer #(
    .MAX_COMBO    (MAX_COMBO),
    .COMBO_WINDOW (COMBO_WINDOW),
    .TMR_W        (TMR_W)
  ) u_combo_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (round_start | round_end),
    .hit_evt (hit_evt),
    .combo   (combo_w)
  );

  assign bus.score      = score_q;
  assign bus.high_score = high_q;
  assign bus.combo      = combo_w;
  assign bus.new_record = new_record_q;
  assign bus.playing    = playing_q;

endmodule

// File: tb/tb_score_keeper.sv
// -----------------------------------------------------------------------------
// tb_score_keeper
// Directed bench for score_keeper with a 20-cycle combo window.
// Inputs change 1 time unit after a rising edge; outputs are compared there.
// -----------------------------------------------------------------------------
module tb_score_keeper;

  localparam int WIN = 20;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  score_keeper_if bus ();

  score_keeper #(
    .MAX_SCORE    (99),
    .MAX_COMBO    (3),
    .COMBO_WINDOW (WIN),
    .TMR_W        (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int   pre;        // idle cycles (all inputs low) before this row
    logic start;
    logic game_over;
    logic hit;
    int   score;
    int   high;
    int   combo;
    logic nr;
    logic play;
  } vec_t;

  vec_t tbl [16];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.start     = 1'b0;
    bus.game_over = 1'b0;
    bus.hit       = 1'b0;
    repeat (n) tick();
  endtask

  task automatic pulse_hit();
    bus.hit = 1'b1;
    tick();
    bus.hit = 1'b0;
    tick();
  endtask

  task automatic check_all(input string tag, input int s, input int h, input int c,
                           input logic nr, input logic p);
    check({tag, ".score"},      {1'b0, bus.score},      8'(s));
    check({tag, ".high_score"}, {1'b0, bus.high_score}, 8'(h));
    check({tag, ".combo"},      {6'b0, bus.combo},      8'(c));
    check({tag, ".new_record"}, {7'b0, bus.new_record}, {7'b0, nr});
    check({tag, ".playing"},    {7'b0, bus.playing},    {7'b0, p});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // pre, start, game_over, hit, score, high, combo, nr, play
    // Round 1: three hits 10 cycles apart -> 1, 3, 6, record 6.
    tbl[0]  = '{0,  1'b1, 1'b0, 1'b0, 0, 0, 1, 1'b0, 1'b1};
    tbl[1]  = '{0,  1'b0, 1'b0, 1'b1, 1, 0, 2, 1'b0, 1'b1};
    tbl[2]  = '{9,  1'b0, 1'b0, 1'b1, 3, 0, 3, 1'b0, 1'b1};
    tbl[3]  = '{9,  1'b0, 1'b0, 1'b1, 6, 0, 3, 1'b0, 1'b1};
    tbl[4]  = '{1,  1'b0, 1'b1, 1'b0, 6, 6, 1, 1'b1, 1'b0};
    // Round 2: equal score 6 is not a record.
    tbl[5]  = '{2,  1'b1, 1'b0, 1'b0, 0, 6, 1, 1'b0, 1'b1};
    tbl[6]  = '{1,  1'b0, 1'b0, 1'b1, 1, 6, 2, 1'b0, 1'b1};
    tbl[7]  = '{1,  1'b0, 1'b0, 1'b1, 3, 6, 3, 1'b0, 1'b1};
    tbl[8]  = '{1,  1'b0, 1'b0, 1'b1, 6, 6, 3, 1'b0, 1'b1};
    tbl[9]  = '{1,  1'b0, 1'b1, 1'b0, 6, 6, 1, 1'b0, 1'b0};
    // Round 3: reach 4 via a combo timeout, then game_over with a hit edge.
    tbl[10] = '{1,  1'b1, 1'b0, 1'b0, 0, 6, 1, 1'b0, 1'b1};
    tbl[11] = '{1,  1'b0, 1'b0, 1'b1, 1, 6, 2, 1'b0, 1'b1};
    tbl[12] = '{21, 1'b0, 1'b0, 1'b1, 2, 6, 2, 1'b0, 1'b1};
    tbl[13] = '{1,  1'b0, 1'b0, 1'b1, 4, 6, 3, 1'b0, 1'b1};
    tbl[14] = '{1,  1'b0, 1'b1, 1'b1, 4, 6, 1, 1'b0, 1'b0};
    // In OVER a hit edge is ignored.
    tbl[15] = '{1,  1'b0, 1'b0, 1'b1, 4, 6, 1, 1'b0, 1'b0};

    // Reset
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.game_over = 1'b0;
    bus.hit       = 1'b0;
    tick();
    tick();
    check_all("reset", 0, 0, 1, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    check_all("idle_after_reset", 0, 0, 1, 1'b0, 1'b0);

    // Table-driven rounds
    for (int i = 0; i < 16; i++) begin
      idle(tbl[i].pre);
      bus.start     = tbl[i].start;
      bus.game_over = tbl[i].game_over;
      bus.hit       = tbl[i].hit;
      tick();
      check_all($sformatf("vec%0d", i), tbl[i].score, tbl[i].high,
                tbl[i].combo, tbl[i].nr, tbl[i].play);
    end
    idle(1);

    // Combo window: lost exactly WIN edges after the hit edge.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.hit   = 1'b1;
    tick();
    check("win.first_score", {1'b0, bus.score}, 8'd1);
    check("win.first_combo", {6'b0, bus.combo}, 8'd2);
    bus.hit = 1'b0;
    repeat (WIN - 1) tick();
    check("win.combo_at_19", {6'b0, bus.combo}, 8'd2);
    tick();
    check("win.combo_at_20", {6'b0, bus.combo}, 8'd1);
    bus.hit = 1'b1;
    tick();
    check("win.second_score", {1'b0, bus.score}, 8'd2);
    check("win.second_combo", {6'b0, bus.combo}, 8'd2);
    bus.hit = 1'b0;

    // Held hit level counts once.
    bus.game_over = 1'b1;
    tick();
    bus.game_over = 1'b0;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.hit   = 1'b1;
    repeat (50) tick();
    bus.hit = 1'b0;
    tick();
    check("hold.score", {1'b0, bus.score}, 8'd1);

    // Saturation: preload 97 with combo 3, then 99, then 99 again.
    bus.game_over = 1'b1;
    tick();
    bus.game_over = 1'b0;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    check("sat.round_clear", {1'b0, bus.score}, 8'd0);
    pulse_hit();              // 1, combo 2
    idle(WIN);                // combo expires
    pulse_hit();              // 2, combo 2
    pulse_hit();              // 4, combo 3
    repeat (31) pulse_hit();  // 4 + 93 = 97
    check("sat.preload_score", {1'b0, bus.score}, 8'd97);
    check("sat.preload_combo", {6'b0, bus.combo}, 8'd3);
    pulse_hit();
    check("sat.clamp_99", {1'b0, bus.score}, 8'd99);
    pulse_hit();
    check("sat.hold_99", {1'b0, bus.score}, 8'd99);
    check("sat.combo", {6'b0, bus.combo}, 8'd3);
    bus.game_over = 1'b1;
    tick();
    bus.game_over = 1'b0;
    check_all("sat.over", 99, 99, 1, 1'b1, 1'b0);

    // start together with game_over in PLAYING: game_over wins.
    bus.start = 1'b1;
    tick();
    check_all("sg.start", 0, 99, 1, 1'b0, 1'b1);
    bus.game_over = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.game_over = 1'b0;
    check_all("sg.both", 0, 99, 1, 1'b0, 1'b0);
    tick();
    check("sg.stays_over", {7'b0, bus.playing}, 8'd0);

    // Reset mid-round clears everything at once, including high_score.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    pulse_hit();
    check("mid.score_before", {1'b0, bus.score}, 8'd1);
    rst = 1'b1;
    #1;
    check_all("mid.reset", 0, 0, 1, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_all("mid.restart", 0, 0, 1, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
Game-score state machine that feeds the 7-bit decimal score input of the ASCII score converter.
- Counts hit events during a round, with a combo multiplier and saturation at 99.
- Tracks a session high score.
- Sits between the collision/game-logic stage and the score-to-ASCII display path.
- `score` and `high_score` outputs are always in range 0..99, so the downstream converter never receives an out-of-range value.

Parameters:
MAX_SCORE, 99, saturation ceiling for score and high_score (must be ≤ 99).
MAX_COMBO, 3, largest points value awarded per hit.
COMBO_WINDOW, 65_000_000, clock cycles after a hit within which the next hit extends the combo (1 s at 65 MHz).
TMR_W, 26, combo timer width; must satisfy 2^TMR_W > COMBO_WINDOW.

Ports:
clk  in  1  system clock (65 MHz pixel domain)
rst  in  1  reset, asynchronous, active-high
start  in  1  synchronous level; begins a new round
game_over  in  1  synchronous level; ends the current round
hit  in  1  synchronous level from collision logic; each rising edge is one hit
score  out  7  current round score, 0..MAX_SCORE
high_score  out  7  best score since reset, 0..MAX_SCORE
combo  out  2  points value the next hit will award, 1..MAX_COMBO
new_record  out  1  high after a round that beat high_score
playing  out  1  high while in PLAYING

Behaviour:
- Reset values (async, active-high): state=IDLE, score=0, high_score=0, combo=1, new_record=0, playing=0, hit_d=0, timer=0.
- Hit detection: hit_d <= hit every cycle in every state.
  - A hit event is hit & ~hit_d, sampled in PLAYING only.
  - A level held high counts once.
- States:
  - IDLE: start -> PLAYING.
  - PLAYING: game_over -> OVER.
  - OVER: start -> PLAYING.
- Entering PLAYING, in the same edge as the transition:
  - score <= 0, combo <= 1, timer <= 0, new_record <= 0.
- Scoring, on the edge where a hit event is sampled in PLAYING:
  - score <= min(score + combo, MAX_SCORE); use 8-bit intermediate sum, no wrap.
  - combo <= min(combo + 1, MAX_COMBO).
  - timer <= COMBO_WINDOW.
  - Latency: score reflects the hit one cycle after the first sampled-high hit cycle.
- Combo timeout, in PLAYING with no hit event:
  - If timer > 1, timer decrements.
  - If timer == 1, timer <= 0 and combo <= 1.
  - If timer == 0, it holds.
  - The combo is therefore lost exactly COMBO_WINDOW cycles after the last hit.
- Round end, on the PLAYING->OVER edge:
  - If score > high_score: high_score <= score and new_record <= 1. An equal score is not a record.
  - score holds its final value in OVER.
  - combo <= 1, timer <= 0.
- Simultaneous events:
  - game_over together with a hit event in PLAYING: game_over wins; the hit is not scored.
  - start together with game_over in PLAYING: game_over wins.
  - start in PLAYING is otherwise ignored; there is no mid-round restart.
- Idle states: in IDLE and OVER, hits are ignored and score, high_score and new_record hold.
- Saturation: at score=MAX_SCORE, further hits leave score at MAX_SCORE; combo still advances.
- Reset mid-round: everything returns to its reset value immediately; high_score is lost.
- Outputs: all are registered, with no combinational path from inputs to outputs. playing = (state==PLAYING), registered.

Decomposition:
- Package score_pkg holds:
  - state encoding (IDLE=2'd0, PLAYING=2'd1, OVER=2'd2; 2'd3 recovers to IDLE);
  - MAX_SCORE default;
  - score width constant (7).
- One natural sub-module, combo_timer. It contains the timer, the combo counter and the timeout logic. Inputs: clk, rst, clear, hit_evt. Output: combo. score_keeper holds the FSM, hit edge detect, score and high-score registers.

Test Plan:
1. Reset, start pulse, three hits 10 cycles apart -> score 1, 3, 6; combo 2, 3, 3; playing=1.
2. COMBO_WINDOW=20: hit, wait 20 cycles, hit -> score 1 then 2; combo 1 at cycle 20 after first hit.
3. Hold hit high 50 cycles -> exactly one point is counted.
4. Preload via hits to score 97 (combo 3), hit -> score 99; hit again -> 99, with no wrap to 2.
5. Score 6, game_over -> OVER, high_score=6, new_record=1.
   - Then start, score 6, game_over -> high_score=6, new_record=0.
6. game_over and a hit edge in the same cycle at score 4 -> score stays 4.
   - Also assert rst mid-round -> all outputs 0 in the same cycle, combo=1.
